cpu_run_ctrl: RTL and testbench

Run controller between the board I/O and the cpu core, driving its rst_n and GPIO_in. It synchronizes and debounces the push-buttons, sequences the core through reset-hold / halt / single-step / free-run via a clock-enable, and forwards switch data. It captures the core's GPIO_out into a display register with a one-cycle update strobe.

---
 rtl/cpu_run_ctrl.sv | 170 +++++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl.sv
// Run controller between board I/O and the cpu core: synchronizes and debounces
// the buttons, sequences reset-hold/halt/step/run via cpu_en, and captures GPIO_out.
module cpu_run_ctrl #(
    parameter int SW_W            = 18,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int RESET_CYCLES    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [SW_W-1:0] sw_raw,
    input  logic            key_step_raw,
    input  logic            key_run_raw,
    input  logic            key_rst_raw,
    input  logic [31:0]     cpu_gpio_out,
    output logic            cpu_rst_n,
    output logic            cpu_en,
    output logic [31:0]     gpio_in,
    output logic [31:0]     disp_out,
    output logic            disp_valid,
    output logic [1:0]      run_state,
    output logic [31:0]     instr_count
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(RESET_CYCLES + 1);

    // Key vector bit order: 0 = step, 1 = run, 2 = core reset.
    localparam int K_STEP = 0;
    localparam int K_RUN  = 1;
    localparam int K_RST  = 2;

    typedef enum logic [1:0] {
        RST_HOLD = 2'd0,
        HALT     = 2'd1,
        STEP     = 2'd2,
        RUN      = 2'd3
    } state_e;

    logic [SW_W-1:0]   sw_s1_q, sw_s2_q;
    logic [2:0]        key_s1_q, key_s2_q;
    logic [2:0]        key_db_q, key_db_prev_q;
    logic [DB_W-1:0]   db_cnt_q [3];
    logic [2:0]        key_evt;

    state_e            state_q;
    logic [HOLD_W-1:0] hold_cnt_q;
    logic [31:0]       instr_cnt_q;

    logic              en_dly_q;
    logic [31:0]       disp_q;
    logic              disp_vld_q;

    logic [2:0]        key_raw;

    assign key_raw = {key_rst_raw, key_run_raw, key_step_raw};

    always_ff @(posedge clk) begin
        if (rst) begin
            sw_s1_q  <= '0;
            sw_s2_q  <= '0;
            key_s1_q <= '0;
            key_s2_q <= '0;
        end else begin
            sw_s1_q  <= sw_raw;
            sw_s2_q  <= sw_s1_q;
            key_s1_q <= key_raw;
            key_s2_q <= key_s1_q;
        end
    end

    // A pending level change must stay stable for DEBOUNCE_CYCLES samples;
    // any return to the current debounced level discards the progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_db_q      <= '0;
            key_db_prev_q <= '0;
            for (int k = 0; k < 3; k++) begin
                db_cnt_q[k] <= '0;
            end
        end else begin
            key_db_prev_q <= key_db_q;
            for (int k = 0; k < 3; k++) begin
                if (key_s2_q[k] == key_db_q[k]) begin
                    db_cnt_q[k] <= '0;
                end else if (db_cnt_q[k] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    key_db_q[k] <= key_s2_q[k];
                    db_cnt_q[k] <= '0;
                end else begin
                    db_cnt_q[k] <= db_cnt_q[k] + DB_W'(1);
                end
            end
        end
    end

    assign key_evt = key_db_q & ~key_db_prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RST_HOLD;
            hold_cnt_q  <= '0;
            instr_cnt_q <= '0;
        end else if (key_evt[K_RST]) begin
            state_q     <= RST_HOLD;
            hold_cnt_q  <= '0;
            instr_cnt_q <= '0;
        end else begin
            case (state_q)
                RST_HOLD: begin
                    instr_cnt_q <= '0;
                    if (hold_cnt_q == HOLD_W'(RESET_CYCLES - 1)) begin
                        hold_cnt_q <= '0;
                        state_q    <= HALT;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
                    end
                end
                HALT: begin
                    if (key_evt[K_RUN]) begin
                        state_q <= RUN;
                    end else if (key_evt[K_STEP]) begin
                        state_q <= STEP;
                    end
                end
                STEP: begin
                    instr_cnt_q <= instr_cnt_q + 32'd1;
                    state_q     <= HALT;
                end
                RUN: begin
                    instr_cnt_q <= instr_cnt_q + 32'd1;
                    if (key_evt[K_RUN]) begin
                        state_q <= HALT;
                    end
                end
                default: begin
                    state_q    <= RST_HOLD;
                    hold_cnt_q <= '0;
                end
            endcase
        end
    end

    assign cpu_rst_n   = (state_q != RST_HOLD);
    assign cpu_en      = (state_q == STEP) || (state_q == RUN);
    assign run_state   = state_q;
    assign instr_count = instr_cnt_q;
    assign gpio_in     = 32'(sw_s2_q);

    // The core's GPIO_out settles after the edge that ends an enabled cycle,
    // so it is sampled one edge later; this also lets the last capture finish
    // after cpu_en has already dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            en_dly_q   <= 1'b0;
            disp_q     <= '0;
            disp_vld_q <= 1'b0;
        end else begin
            en_dly_q <= cpu_en;
            if (en_dly_q && (cpu_gpio_out != disp_q)) begin
                disp_q     <= cpu_gpio_out;
                disp_vld_q <= 1'b1;
            end else begin
                disp_vld_q <= 1'b0;
            end
        end
    end

    assign disp_out   = disp_q;
    assign disp_valid = disp_vld_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl with short debounce/reset settings and a tiny
// core model that steps GPIO_out through a fixed sequence on enabled cycles.
module tb_cpu_run_ctrl;

    localparam int SW_W = 18;

    logic            clk = 1'b0;
    logic            rst;
    logic [SW_W-1:0] sw_raw;
    logic            key_step_raw, key_run_raw, key_rst_raw;
    logic [31:0]     cpu_gpio_out = '0;
    logic            cpu_rst_n, cpu_en, disp_valid;
    logic [31:0]     gpio_in, disp_out, instr_count;
    logic [1:0]      run_state;

    int n_checks = 0;
    int n_errors = 0;

    logic        model_on = 1'b0;
    int          model_idx = 0;
    int          en_cnt = 0;
    int          vld_cnt = 0;
    int          step_cnt = 0;
    logic [31:0] seq [4] = '{32'h0, 32'h5, 32'h5, 32'h9};

    always #5 clk = ~clk;

    cpu_run_ctrl #(
        .SW_W(SW_W),
        .DEBOUNCE_CYCLES(4),
        .RESET_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sw_raw(sw_raw),
        .key_step_raw(key_step_raw),
        .key_run_raw(key_run_raw),
        .key_rst_raw(key_rst_raw),
        .cpu_gpio_out(cpu_gpio_out),
        .cpu_rst_n(cpu_rst_n),
        .cpu_en(cpu_en),
        .gpio_in(gpio_in),
        .disp_out(disp_out),
        .disp_valid(disp_valid),
        .run_state(run_state),
        .instr_count(instr_count)
    );

    // Observers and core model, sampled mid-cycle.
    always @(negedge clk) begin
        if (run_state == 2'd0) en_cnt <= 0;
        else if (cpu_en) en_cnt <= en_cnt + 1;
        if (disp_valid) vld_cnt <= vld_cnt + 1;
        if (run_state == 2'd2) step_cnt <= step_cnt + 1;
        if (model_on && cpu_en && model_idx < 3) begin
            model_idx    <= model_idx + 1;
            cpu_gpio_out <= seq[model_idx + 1];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          snap;
        int          run_bad;
        logic        prev_en;
        logic [31:0] disp_snap;

        rst = 1'b1;
        sw_raw = '0;
        key_step_raw = 1'b0;
        key_run_raw = 1'b0;
        key_rst_raw = 1'b0;
        tick(2);
        chk("rst_state", 32'(run_state), 32'd0);
        chk("rst_rst_n", 32'(cpu_rst_n), 32'd0);
        chk("rst_en", 32'(cpu_en), 32'd0);
        chk("rst_gpio_in", gpio_in, 32'd0);
        chk("rst_disp", disp_out, 32'd0);
        chk("rst_valid", 32'(disp_valid), 32'd0);
        chk("rst_instr", instr_count, 32'd0);

        rst = 1'b0;
        chk("hold_c1", 32'(run_state), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_state", 32'(run_state), 32'd0);
            chk("hold_rst_n", 32'(cpu_rst_n), 32'd0);
        end
        tick();
        chk("halt_state", 32'(run_state), 32'd1);
        chk("halt_rst_n", 32'(cpu_rst_n), 32'd1);
        chk("halt_en", 32'(cpu_en), 32'd0);
        chk("halt_instr", instr_count, 32'd0);
        chk("halt_disp", disp_out, 32'd0);

        sw_raw = 18'h000EA;
        tick();
        chk("sw_edge1", gpio_in, 32'h0);
        tick();
        chk("sw_edge2", gpio_in, 32'h000000EA);

        // 3-cycle glitch on step must be filtered out.
        key_step_raw = 1'b1;
        tick(3);
        key_step_raw = 1'b0;
        tick(12);
        chk("glitch_state", 32'(run_state), 32'd1);
        chk("glitch_en_cycles", 32'(en_cnt), 32'd0);

        key_step_raw = 1'b1;
        tick(10);
        key_step_raw = 1'b0;
        tick(12);
        chk("step_en_cycles", 32'(en_cnt), 32'd1);
        chk("step_instr", instr_count, 32'd1);
        chk("step_state", 32'(run_state), 32'd1);
        chk("step_seen", 32'(step_cnt), 32'd1);

        model_on = 1'b1;
        key_run_raw = 1'b1;
        tick(10);
        key_run_raw = 1'b0;
        chk("run_state", 32'(run_state), 32'd3);
        run_bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!cpu_en) run_bad++;
        end
        chk("run_en_gaps", 32'(run_bad), 32'd0);
        chk("run_disp", disp_out, 32'h9);
        chk("run_valid_pulses", 32'(vld_cnt), 32'd2);

        key_run_raw = 1'b1;
        tick(10);
        key_run_raw = 1'b0;
        tick(12);
        chk("halt2_state", 32'(run_state), 32'd1);
        chk("halt2_instr", instr_count, 32'(en_cnt));
        chk("halt2_disp", disp_out, 32'h9);

        snap = step_cnt;
        key_run_raw = 1'b1;
        key_step_raw = 1'b1;
        tick(10);
        key_run_raw = 1'b0;
        key_step_raw = 1'b0;
        tick(4);
        chk("both_state", 32'(run_state), 32'd3);
        chk("both_no_step", 32'(step_cnt), 32'(snap));

        key_step_raw = 1'b1;
        tick(10);
        key_step_raw = 1'b0;
        tick(12);
        chk("run_step_state", 32'(run_state), 32'd3);
        chk("run_step_en", 32'(cpu_en), 32'd1);

        sw_raw = 18'h3FFFF;
        tick(2);
        chk("sw_in_run", gpio_in, 32'h0003FFFF);

        force dut.instr_cnt_q = 32'hFFFFFFFE;
        #1;
        release dut.instr_cnt_q;
        tick();
        chk("wrap_max", instr_count, 32'hFFFFFFFF);
        tick();
        chk("wrap_zero", instr_count, 32'h0);

        disp_snap = disp_out;
        force dut.instr_cnt_q = 32'hFFFFFFFE;
        #1;
        release dut.instr_cnt_q;
        key_rst_raw = 1'b1;
        prev_en = cpu_en;
        for (int i = 0; i < 20; i++) begin
            if (run_state == 2'd0) break;
            prev_en = cpu_en;
            tick();
        end
        key_rst_raw = 1'b0;
        chk("rstevt_state", 32'(run_state), 32'd0);
        chk("rstevt_prev_en", 32'(prev_en), 32'd1);
        chk("rstevt_en", 32'(cpu_en), 32'd0);
        chk("rstevt_rst_n", 32'(cpu_rst_n), 32'd0);
        chk("rstevt_instr", instr_count, 32'd0);
        chk("rstevt_disp", disp_out, 32'h9);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rstevt_hold", 32'(run_state), 32'd0);
        end
        tick();
        chk("rstevt_halt", 32'(run_state), 32'd1);
        chk("rstevt_instr_halt", instr_count, 32'd0);
        chk("rstevt_disp_kept", disp_out, disp_snap);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
